rv_dmem_resp: RTL and testbench
===============================

Name: rv_dmem_resp

Overview:
- Data-memory responder for the multicycle RISC-V core: the target end of the core's load/store memory interface.
- Accepts one word request at a time from the control/datapath side (read or write), inserts a programmable number of wait states, then returns a response with read data and an error flag.
- Holds the response until the requester takes it.
- Replaces the zero-latency memory model so the control FSM can be exercised against realistic stalls.

Parameters:
- DEPTH_WORDS, 256, number of 32-bit words in the internal array; power of two, 4..4096.
- LATENCY, 2, wait states between request acceptance and the memory access/response; 0..15.

Ports:
- clk  input  1  clock, all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- req_valid  input  1  requester presents a request.
- req_write  input  1  1 = store (sw), 0 = load (lw).
- req_addr  input  32  byte address.
- req_wdata  input  32  store data.
- req_ready  output  1  responder can accept a request this cycle.
- rsp_valid  output  1  response available.
- rsp_ready  input  1  requester takes the response this cycle.
- rsp_rdata  output  32  load data; 0 for stores and errors.
- rsp_err  output  1  request was misaligned or out of range.

Behaviour:
- Reset is synchronous and active-high: rst sampled high at a rising edge of clk forces state IDLE and clears the wait counter, latched request, rsp_rdata and rsp_err.
  - Reset values: req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0.
  - Array contents are not cleared by reset.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - req_ready=1; all other outputs 0.
  - Acceptance: req_valid && req_ready at edge E latches req_write, req_addr, req_wdata.
  - At E, go to WAIT with counter=LATENCY-1 if LATENCY>0; otherwise go directly to RESP and perform the access.
- WAIT:
  - req_ready=0, rsp_valid=0.
  - Counter decrements each edge.
  - At the edge where counter==0, perform the access and go to RESP.
- Access, performed on the edge entering RESP:
  - Error check: err = (addr[1:0]!=0) || (addr[31:2] >= DEPTH_WORDS).
  - Read, no error: rsp_rdata <= mem[addr[31:2]].
  - Write, no error: mem[addr[31:2]] <= wdata; rsp_rdata <= 0.
  - Any error: no array write, rsp_rdata <= 0, rsp_err <= 1.
- RESP:
  - rsp_valid=1; rsp_rdata and rsp_err stable while held; req_ready=0.
  - On rsp_ready at an edge, return to IDLE.
  - rsp_ready may be held high permanently.
- Timing: rsp_valid is first high in the cycle after edge E+LATENCY.
  - Next request is accepted no earlier than the edge after the response handshake edge.
  - Back-to-back throughput is one request per LATENCY+2 cycles.
- req_valid while req_ready=0 is ignored; the requester must hold it. req_* fields are sampled only at acceptance, so later changes have no effect.
- rsp_ready outside RESP is ignored.
- Reset mid-operation:
  - In WAIT: the pending access is dropped and a pending write is never committed.
  - In RESP: the response is discarded; a write already committed stays in the array.
- Simultaneous rst and req_valid: rst wins and nothing is accepted.

Test Plan:
1. LATENCY=2. Write addr 0x10 data 0xDEADBEEF, then read 0x10. -> Write response has rsp_valid high in the cycle after edge E+2, rsp_err=0, rsp_rdata=0; read returns 0xDEADBEEF.
2. LATENCY=0, rsp_ready tied 1. Back-to-back reads of 0x0 and 0x4. -> Each rsp_valid appears the cycle after acceptance; req_ready low for exactly 1 cycle; one accept every 2 cycles.
3. Misaligned write to 0x12 with data 0x1234, then read 0x10. -> Write gives rsp_err=1; read returns the prior contents unchanged, rsp_err=0.
4. DEPTH_WORDS=256. Read 0x400 (word 256). -> rsp_err=1, rsp_rdata=0. Read 0x3FC -> rsp_err=0.
5. Backpressure: hold rsp_ready=0 for 5 cycles in RESP. -> rsp_valid and rsp_rdata stay constant and req_ready stays 0; a request offered meanwhile is accepted only after the release handshake.
6. Assert rst for one edge while in WAIT on a write of 0xCAFEF00D to 0x20 (prior value 0x11111111). -> Outputs return to reset values; a subsequent read of 0x20 returns 0x11111111.

Source files
------------

// File: rtl/rv_dmem_resp.sv
// rv_dmem_resp: data-memory responder for the multicycle RISC-V core.
// Accepts one word request at a time (load or store), waits LATENCY cycles,
// performs the access, then holds the response until the requester takes it.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   req_valid  requester presents a request
//   req_write  1 = store, 0 = load
//   req_addr   byte address
//   req_wdata  store data
//   req_ready  responder can accept a request this cycle
//   rsp_valid  response available
//   rsp_ready  requester takes the response this cycle
//   rsp_rdata  load data (0 for stores and errors)
//   rsp_err    request was misaligned or out of range
module rv_dmem_resp #(
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY     = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        req_ready,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int          AW       = $clog2(DEPTH_WORDS);
  localparam logic [3:0]  CNT_INIT = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;
  localparam logic [29:0] DEPTH_L  = 30'(DEPTH_WORDS);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t        state, state_nxt;
  logic [3:0]    cnt;
  logic          lat_write;
  logic [31:0]   lat_addr;
  logic [31:0]   lat_wdata;
  logic [31:0]   mem [DEPTH_WORDS];
  logic [31:0]   rdata_q;
  logic          err_q;

  logic          accept;
  logic          do_access;
  logic          acc_write;
  logic [31:0]   acc_addr;
  logic [31:0]   acc_wdata;
  logic          acc_err;
  logic [AW-1:0] acc_idx;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    do_access = 1'b0;
    case (state)
      IDLE: begin
        if (req_valid) begin
          accept = 1'b1;
          if (LATENCY == 0) begin
            do_access = 1'b1;
            state_nxt = RESP;
          end else begin
            state_nxt = WAIT;
          end
        end
      end
      WAIT: begin
        if (cnt == 4'd0) begin
          do_access = 1'b1;
          state_nxt = RESP;
        end
      end
      RESP: begin
        if (rsp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // With zero latency the access happens on the acceptance edge itself, so
  // it must use the live request fields instead of the latched copy.
  always_comb begin
    acc_write = lat_write;
    acc_addr  = lat_addr;
    acc_wdata = lat_wdata;
    if (state == IDLE) begin
      acc_write = req_write;
      acc_addr  = req_addr;
      acc_wdata = req_wdata;
    end
    acc_err = (acc_addr[1:0] != 2'b00) || (acc_addr[31:2] >= DEPTH_L);
    acc_idx = acc_addr[AW+1:2];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt       <= 4'd0;
      lat_write <= 1'b0;
      lat_addr  <= 32'd0;
      lat_wdata <= 32'd0;
      rdata_q   <= 32'd0;
      err_q     <= 1'b0;
    end else begin
      if (accept) begin
        cnt       <= CNT_INIT;
        lat_write <= req_write;
        lat_addr  <= req_addr;
        lat_wdata <= req_wdata;
      end else if (state == WAIT && cnt != 4'd0) begin
        cnt <= cnt - 4'd1;
      end
      if (do_access) begin
        err_q   <= acc_err;
        rdata_q <= (!acc_err && !acc_write) ? mem[acc_idx] : 32'd0;
      end
    end
  end

  // Array is never reset; a reset edge must still suppress a pending store.
  always_ff @(posedge clk) begin
    if (!rst && do_access && acc_write && !acc_err) mem[acc_idx] <= acc_wdata;
  end

  assign req_ready = (state == IDLE);
  assign rsp_valid = (state == RESP);
  assign rsp_rdata = rsp_valid ? rdata_q : 32'd0;
  assign rsp_err   = rsp_valid & err_q;

endmodule

// File: tb/tb_rv_dmem_resp.sv
module tb_rv_dmem_resp;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // DUT A: LATENCY=2
  logic        a_req_valid, a_req_write, a_req_ready, a_rsp_valid, a_rsp_ready, a_rsp_err;
  logic [31:0] a_req_addr, a_req_wdata, a_rsp_rdata;
  // DUT B: LATENCY=0, rsp_ready tied high
  logic        b_req_valid, b_req_write, b_req_ready, b_rsp_valid, b_rsp_ready, b_rsp_err;
  logic [31:0] b_req_addr, b_req_wdata, b_rsp_rdata;

  int checks = 0;
  int errors = 0;

  rv_dmem_resp #(.DEPTH_WORDS(256), .LATENCY(2)) u_dut_a (
    .clk(clk), .rst(rst),
    .req_valid(a_req_valid), .req_write(a_req_write), .req_addr(a_req_addr),
    .req_wdata(a_req_wdata), .req_ready(a_req_ready),
    .rsp_valid(a_rsp_valid), .rsp_ready(a_rsp_ready),
    .rsp_rdata(a_rsp_rdata), .rsp_err(a_rsp_err)
  );

  rv_dmem_resp #(.DEPTH_WORDS(256), .LATENCY(0)) u_dut_b (
    .clk(clk), .rst(rst),
    .req_valid(b_req_valid), .req_write(b_req_write), .req_addr(b_req_addr),
    .req_wdata(b_req_wdata), .req_ready(b_req_ready),
    .rsp_valid(b_rsp_valid), .rsp_ready(b_rsp_ready),
    .rsp_rdata(b_rsp_rdata), .rsp_err(b_rsp_err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Present a request on DUT A for one edge, then scramble the fields.
  task automatic issue(input string tag, input logic w, input logic [31:0] a, input logic [31:0] d);
    a_req_write = w;
    a_req_addr  = a;
    a_req_wdata = d;
    a_req_valid = 1'b1;
    check({tag, "_req_ready"}, a_req_ready, 1);
    tick();
    a_req_valid = 1'b0;
    a_req_write = ~w;
    a_req_addr  = 32'hFFFF_FFFC;
    a_req_wdata = 32'h0BAD_0BAD;
  endtask

  task automatic wait_rsp(input string tag, input int exp_lat);
    int n = 0;
    while (!a_rsp_valid && n < 40) begin
      tick();
      n++;
    end
    check({tag, "_latency"}, n, exp_lat);
  endtask

  task automatic take(input string tag);
    a_rsp_ready = 1'b1;
    tick();
    a_rsp_ready = 1'b0;
    check({tag, "_idle_rsp_valid"}, a_rsp_valid, 0);
    check({tag, "_idle_req_ready"}, a_req_ready, 1);
    check({tag, "_idle_rdata"}, a_rsp_rdata, 0);
  endtask

  task automatic xact(input string tag, input logic w, input logic [31:0] a,
                      input logic [31:0] d, input logic [31:0] exp_rdata, input logic exp_err);
    issue(tag, w, a, d);
    wait_rsp(tag, 2);
    check({tag, "_rdata"}, a_rsp_rdata, exp_rdata);
    check({tag, "_err"}, a_rsp_err, exp_err);
    take(tag);
  endtask

  logic        b_w [4]  = '{1'b1, 1'b1, 1'b0, 1'b0};
  logic [31:0] b_a [4]  = '{32'h0, 32'h4, 32'h0, 32'h4};
  logic [31:0] b_d [4]  = '{32'hA5A5_A5A5, 32'h0F0F_0F0F, 32'h0, 32'h0};
  logic [31:0] b_r [4]  = '{32'h0, 32'h0, 32'hA5A5_A5A5, 32'h0F0F_0F0F};

  initial begin
    rst = 1'b1;
    a_req_valid = 0; a_req_write = 0; a_req_addr = 0; a_req_wdata = 0; a_rsp_ready = 0;
    b_req_valid = 0; b_req_write = 0; b_req_addr = 0; b_req_wdata = 0; b_rsp_ready = 1;
    tick();
    tick();
    rst = 1'b0;

    // Reset state
    check("rst_a_req_ready", a_req_ready, 1);
    check("rst_a_rsp_valid", a_rsp_valid, 0);
    check("rst_a_rdata", a_rsp_rdata, 0);
    check("rst_a_err", a_rsp_err, 0);
    check("rst_b_req_ready", b_req_ready, 1);
    check("rst_b_rsp_valid", b_rsp_valid, 0);

    // Write then read, LATENCY=2
    xact("wr10", 1'b1, 32'h10, 32'hDEAD_BEEF, 32'h0, 1'b0);
    xact("rd10", 1'b0, 32'h10, 32'h0, 32'hDEAD_BEEF, 1'b0);

    // Zero latency, back-to-back with req_valid held and rsp_ready tied high
    b_req_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      b_req_write = b_w[i];
      b_req_addr  = b_a[i];
      b_req_wdata = b_d[i];
      check($sformatf("b%0d_req_ready_pre", i), b_req_ready, 1);
      tick();
      check($sformatf("b%0d_rsp_valid", i), b_rsp_valid, 1);
      check($sformatf("b%0d_req_ready_busy", i), b_req_ready, 0);
      check($sformatf("b%0d_rdata", i), b_rsp_rdata, b_r[i]);
      check($sformatf("b%0d_err", i), b_rsp_err, 0);
      tick();
      check($sformatf("b%0d_rsp_valid_off", i), b_rsp_valid, 0);
    end
    b_req_valid = 1'b0;

    // Misaligned store leaves the array untouched
    xact("wr12_mis", 1'b1, 32'h12, 32'h0000_1234, 32'h0, 1'b1);
    xact("rd10_after_mis", 1'b0, 32'h10, 32'h0, 32'hDEAD_BEEF, 1'b0);

    // Range boundary
    xact("rd400_oor", 1'b0, 32'h400, 32'h0, 32'h0, 1'b1);
    xact("wr3fc", 1'b1, 32'h3FC, 32'h7777_8888, 32'h0, 1'b0);
    xact("rd3fc", 1'b0, 32'h3FC, 32'h0, 32'h7777_8888, 1'b0);

    // Backpressure with a competing request offered during RESP
    issue("bp_rd", 1'b0, 32'h10, 32'h0);
    wait_rsp("bp_rd", 2);
    a_req_valid = 1'b1;
    a_req_write = 1'b1;
    a_req_addr  = 32'h10;
    a_req_wdata = 32'h0000_0055;
    for (int i = 0; i < 5; i++) begin
      check($sformatf("bp%0d_rsp_valid", i), a_rsp_valid, 1);
      check($sformatf("bp%0d_rdata", i), a_rsp_rdata, 32'hDEAD_BEEF);
      check($sformatf("bp%0d_req_ready", i), a_req_ready, 0);
      tick();
    end
    a_rsp_ready = 1'b1;
    tick();
    a_rsp_ready = 1'b0;
    check("bp_release_rsp_valid", a_rsp_valid, 0);
    check("bp_release_req_ready", a_req_ready, 1);
    tick();
    a_req_valid = 1'b0;
    check("bp_accept_req_ready", a_req_ready, 0);
    wait_rsp("bp_wr", 2);
    check("bp_wr_err", a_rsp_err, 0);
    take("bp_wr");
    xact("bp_rd_back", 1'b0, 32'h10, 32'h0, 32'h0000_0055, 1'b0);

    // Reset during WAIT drops a pending store; rst also beats a new request
    xact("wr20_init", 1'b1, 32'h20, 32'h1111_1111, 32'h0, 1'b0);
    issue("wr20_drop", 1'b1, 32'h20, 32'hCAFE_F00D);
    check("wait_req_ready", a_req_ready, 0);
    rst = 1'b1;
    a_req_valid = 1'b1;
    a_req_write = 1'b1;
    a_req_addr  = 32'h20;
    a_req_wdata = 32'hCAFE_F00D;
    tick();
    rst = 1'b0;
    a_req_valid = 1'b0;
    check("midrst_req_ready", a_req_ready, 1);
    check("midrst_rsp_valid", a_rsp_valid, 0);
    check("midrst_rdata", a_rsp_rdata, 0);
    check("midrst_err", a_rsp_err, 0);
    tick();
    check("midrst_no_accept", a_req_ready, 1);
    xact("rd20_after_rst", 1'b0, 32'h20, 32'h0, 32'h1111_1111, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
